sdram_rdpipe: RTL and testbench

- Read-data return stage directly downstream of the SDRAM controller.
- Watches the controller's command pins and, after CAS latency, captures SDRAM DQ into a small FIFO.
- Each captured longword is tagged with its burst word index and presented to the 030 data-bus driver with a valid/ack handshake.
- Absorbs burst reads (4 longwords) so the CPU-side logic can consume at its own pace.

---
 rtl/sdram_defines.sv | 28 ++
 rtl/sdram_rdfifo.sv | 61 ++++++
 rtl/sdram_rdpipe.sv | 80 ++++++++
 tb/tb_sdram_rdpipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_defines.sv
// Shared SDRAM definitions: command encodings as seen on {RAS,CAS,WE} and the
// default CAS latency used by the controller and the read-return path.
package sdram_defines;

    typedef enum logic [2:0] {
        CMD_MODE      = 3'b000,
        CMD_REFRESH   = 3'b001,
        CMD_PRECHARGE = 3'b010,
        CMD_ACTIVE    = 3'b011,
        CMD_WRITE     = 3'b100,
        CMD_READ      = 3'b101,
        CMD_BST       = 3'b110,
        CMD_NOP       = 3'b111
    } sdram_cmd_e;

    localparam int CAS_LATENCY = 2;

    // One slot of the read-tag pipeline: a READ in flight and its burst word index.
    typedef struct packed {
        logic       valid;
        logic [1:0] col;
    } rd_tag_t;

    function automatic logic is_read(input logic ras, input logic cas, input logic we);
        return {ras, cas, we} == CMD_READ;
    endfunction

endpackage

// File: rtl/sdram_rdfifo.sv
// Synchronous FIFO with wrap-bit pointers; pop is honoured before push so a
// full FIFO can accept a word in the same cycle it releases one.
module sdram_rdfifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop  = i_pop & ~w_empty & ~i_flush;
    assign w_push = i_push & (~w_full | w_pop) & ~i_flush;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage has no reset; an entry is only observable once written, and
    // the empty case is forced to zero on the read port below.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_drop  = i_push & w_full & ~w_pop & ~i_flush;

endmodule

// File: rtl/sdram_rdpipe.sv
// SDRAM read-data return stage: tags READ commands, captures DQ after CAS
// latency and buffers {word index, data} for the 030 bus side.
module sdram_rdpipe #(
    parameter int CAS_LATENCY = sdram_defines::CAS_LATENCY,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  RAS,
    input  logic                  CAS,
    input  logic                  RAMWE,
    input  logic [1:0]            ACOL,
    input  logic [DATA_WIDTH-1:0] DQ,
    input  logic                  FLUSH,
    input  logic                  DACK,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic [1:0]            DWORD,
    output logic                  DVALID,
    output logic                  FULL,
    output logic                  OVERRUN
);

    import sdram_defines::*;

    rd_tag_t               r_tag [CAS_LATENCY];
    rd_tag_t               r_cap;
    logic [DATA_WIDTH-1:0] r_dq;
    logic                  r_overrun;

    logic                    w_read;
    logic                    w_empty;
    logic                    w_drop;
    logic [DATA_WIDTH+1:0]   w_rdata;

    assign w_read = is_read(RAS, CAS, RAMWE);

    // Slot 0 holds the READ sampled this edge; the last slot feeds the capture register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < CAS_LATENCY; i++) r_tag[i] <= '0;
            r_cap <= '0;
            r_dq  <= '0;
        end else begin
            r_tag[0] <= '{valid: w_read & ~FLUSH, col: ACOL};
            for (int i = 1; i < CAS_LATENCY; i++)
                r_tag[i] <= '{valid: r_tag[i-1].valid & ~FLUSH, col: r_tag[i-1].col};
            r_cap <= '{valid: r_tag[CAS_LATENCY-1].valid & ~FLUSH,
                       col:   r_tag[CAS_LATENCY-1].col};
            if (r_tag[CAS_LATENCY-1].valid) r_dq <= DQ;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)      r_overrun <= 1'b0;
        else if (w_drop) r_overrun <= 1'b1;
    end

    sdram_rdfifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH + 2)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (r_cap.valid),
        .i_pop   (DACK),
        .i_flush (FLUSH),
        .i_wdata ({r_cap.col, r_dq}),
        .o_rdata (w_rdata),
        .o_full  (FULL),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign DOUT    = w_rdata[DATA_WIDTH-1:0];
    assign DWORD   = w_rdata[DATA_WIDTH+1:DATA_WIDTH];
    assign DVALID  = ~w_empty;
    assign OVERRUN = r_overrun;

endmodule

// File: tb/tb_sdram_rdpipe.sv
// Directed plus randomized bench for sdram_rdpipe against a queue-based model
// of READ-to-FIFO timing, pop-before-push ordering, flush and sticky overrun.
module tb_sdram_rdpipe;

    localparam int CL    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] NOP = 3'b111;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          RAS = 1'b1, CAS = 1'b1, RAMWE = 1'b1;
    logic [1:0]    ACOL = '0;
    logic [DW-1:0] DQ = '0;
    logic          FLUSH = 1'b0, DACK = 1'b0;
    logic [DW-1:0] DOUT;
    logic [1:0]    DWORD;
    logic          DVALID, FULL, OVERRUN;

    always #5 CLK = ~CLK;

    sdram_rdpipe #(.CAS_LATENCY(CL), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .RAS(RAS), .CAS(CAS), .RAMWE(RAMWE),
        .ACOL(ACOL), .DQ(DQ), .FLUSH(FLUSH), .DACK(DACK),
        .DOUT(DOUT), .DWORD(DWORD), .DVALID(DVALID), .FULL(FULL), .OVERRUN(OVERRUN)
    );

    // A READ in flight: DQ is taken at cap_edge and enters the FIFO one edge later.
    typedef struct {
        int            cap_edge;
        logic [1:0]    col;
        logic [DW-1:0] data;
    } pend_t;
    typedef struct {
        logic [1:0]    col;
        logic [DW-1:0] data;
    } entry_t;

    pend_t  pend[$];
    entry_t fq[$];
    logic   m_overrun = 1'b0;
    int     edge_n = 0;
    int     tests = 0;
    int     fails = 0;
    string  phase = "reset";

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check({phase, ".dvalid"},  64'(DVALID),  64'(fq.size() != 0));
        check({phase, ".full"},    64'(FULL),    64'(fq.size() == DEPTH));
        check({phase, ".overrun"}, 64'(OVERRUN), 64'(m_overrun));
        if (fq.size() != 0) begin
            check({phase, ".dout"},  64'(DOUT),  64'(fq[0].data));
            check({phase, ".dword"}, 64'(DWORD), 64'(fq[0].col));
        end
    endtask

    task automatic model_reset();
        pend.delete();
        fq.delete();
        m_overrun = 1'b0;
    endtask

    task automatic model_edge();
        entry_t e;
        edge_n++;
        if (FLUSH) begin
            pend.delete();
            fq.delete();
        end else begin
            if (DACK && fq.size() != 0) void'(fq.pop_front());
            foreach (pend[i]) if (pend[i].cap_edge == edge_n) pend[i].data = DQ;
            if (pend.size() != 0 && pend[0].cap_edge + 1 == edge_n) begin
                e.col  = pend[0].col;
                e.data = pend[0].data;
                void'(pend.pop_front());
                if (fq.size() < DEPTH) fq.push_back(e);
                else                   m_overrun = 1'b1;
            end
            if ({RAS, CAS, RAMWE} == RD) pend.push_back('{edge_n + CL, ACOL, '0});
        end
    endtask

    task automatic cycle(input logic [2:0] cmd, input logic [1:0] col, input logic [DW-1:0] dq,
                         input logic flush, input logic dack);
        @(negedge CLK);
        check_outputs();
        {RAS, CAS, RAMWE} = cmd;
        ACOL  = col;
        DQ    = dq;
        FLUSH = flush;
        DACK  = dack;
        @(posedge CLK);
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(NOP, 2'd0, $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("reset.dout",    64'(DOUT),    64'd0);
        check("reset.dword",   64'(DWORD),   64'd0);
        check("reset.dvalid",  64'(DVALID),  64'd0);
        check("reset.full",    64'(FULL),    64'd0);
        check("reset.overrun", 64'(OVERRUN), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        phase = "single";
        cycle(RD,  2'd2, $urandom, 1'b0, 1'b0);
        cycle(NOP, 2'd0, $urandom, 1'b0, 1'b0);
        cycle(NOP, 2'd0, 32'hDEADBEEF, 1'b0, 1'b0);
        cycle(NOP, 2'd0, $urandom, 1'b0, 1'b0);
        #1;
        check("single.dout",  64'(DOUT),  64'hDEADBEEF);
        check("single.dword", 64'(DWORD), 64'd2);
        cycle(NOP, 2'd0, $urandom, 1'b0, 1'b1);
        #1;
        check("single.popped", 64'(DVALID), 64'd0);
        cycle(NOP, 2'd0, $urandom, 1'b0, 1'b1);

        phase = "burst";
        cycle(RD,  2'd0, $urandom,     1'b0, 1'b0);
        cycle(RD,  2'd1, $urandom,     1'b0, 1'b0);
        cycle(RD,  2'd2, 32'h11111111, 1'b0, 1'b0);
        cycle(RD,  2'd3, 32'h22222222, 1'b0, 1'b0);
        cycle(NOP, 2'd0, 32'h33333333, 1'b0, 1'b0);
        cycle(NOP, 2'd0, 32'h44444444, 1'b0, 1'b0);
        cycle(NOP, 2'd0, $urandom,     1'b0, 1'b0);
        #1;
        check("burst.full", 64'(FULL), 64'd1);

        phase = "fullpp";
        cycle(RD,  2'd1, $urandom,     1'b0, 1'b0);
        cycle(NOP, 2'd0, $urandom,     1'b0, 1'b0);
        cycle(NOP, 2'd0, 32'h55555555, 1'b0, 1'b0);
        cycle(NOP, 2'd0, $urandom,     1'b0, 1'b1);
        #1;
        check("fullpp.full",    64'(FULL),    64'd1);
        check("fullpp.overrun", 64'(OVERRUN), 64'd0);
        check("fullpp.head",    64'(DOUT),    64'h22222222);

        phase = "overrun";
        cycle(RD, 2'd3, $urandom, 1'b0, 1'b0);
        idle(3);
        #1;
        check("overrun.set",  64'(OVERRUN), 64'd1);
        check("overrun.head", 64'(DOUT),    64'h22222222);
        for (int i = 0; i < DEPTH; i++) cycle(NOP, 2'd0, $urandom, 1'b0, 1'b1);
        cycle(NOP, 2'd0, $urandom, 1'b1, 1'b0);
        #1;
        check("overrun.after_flush", 64'(OVERRUN), 64'd1);

        phase = "flush";
        for (int i = 0; i < 4; i++) cycle(RD, 2'(i), $urandom, 1'b0, 1'b0);
        cycle(NOP, 2'd0, $urandom, 1'b0, 1'b0);
        cycle(NOP, 2'd0, $urandom, 1'b1, 1'b0);
        #1;
        check("flush.dvalid", 64'(DVALID), 64'd0);
        idle(4);

        phase = "rstmid";
        for (int i = 0; i < 4; i++) cycle(RD, 2'(i), $urandom, 1'b0, 1'b0);
        idle(2);
        {RAS, CAS, RAMWE} = NOP;
        #3 RESET = 1'b0;
        #1;
        model_reset();
        check("rstmid.dvalid",  64'(DVALID),  64'd0);
        check("rstmid.dout",    64'(DOUT),    64'd0);
        check("rstmid.overrun", 64'(OVERRUN), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        idle(5);

        phase = "random";
        for (int i = 0; i < 400; i++) begin
            logic [2:0] cmd;
            cmd = ($urandom_range(0, 1) != 0) ? RD : 3'($urandom_range(0, 7));
            cycle(cmd, 2'($urandom_range(0, 3)), $urandom,
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 4) < 2));
        end
        idle(6);
        @(negedge CLK);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
